fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//   Instruction-fetch front end. Owns the program counter and drives the
//   instruction memory address (PC_in). The memory registers its output one
//   clock after the address is presented. This block tracks that latency and
//   emits instr_pc/instr_valid aligned with the memory's instruction output,
//   so decode can consume {instruction, instr_pc, instr_valid} as one bundle.
//   It also handles stalls, branch redirects, end-of-program halt and a fetch
//   counter.
// PARAMETERS
//   RESET_PC  32'd0   PC value loaded on reset
//   PC_STEP   32'd4   sequential increment (bytes per instruction)
//   PC_LIMIT  32'd28  first address past the program; reaching it halts fetch
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   rst          in   1   asynchronous, active-high reset
//   stall        in   1   decode back-pressure: hold PC and aligned outputs
//   redirect     in   1   branch/jump taken; load redirect_pc
//   redirect_pc  in   32  redirect target address
//   pc_out       out  32  fetch address, wired to instruction memory PC_in
//   instr_pc     out  32  PC of the instruction currently on memory output
//   instr_valid  out  1   memory output is a real instruction for decode
//   halted       out  1   high in state HALTED
//   misalign_err out  1   sticky; a redirect target had bits [1:0] != 0
//   fetch_count  out  16  number of valid instructions delivered, saturating
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-stall or mid-redirect): pc_out=RESET_PC,
//     instr_pc=RESET_PC, instr_valid=0, halted=0, misalign_err=0,
//     fetch_count=0, state=RUN. Reset overrides all inputs.
//   - Latency: the instruction for address A appears on memory output at the
//     edge after A sits on pc_out. At that same edge, instr_pc<=A.
//     instr_valid is then set as defined below.
//   - Priority at each edge: rst > redirect > stall > sequential advance.
//   - Redirect (in RUN or HALTED): pc_out<=redirect_pc & ~32'h3.
//     instr_valid<=0: the instruction captured at this edge belongs to the old
//     path and is squashed. instr_pc<=old pc_out. State goes to RUN.
//     misalign_err<=1 if redirect_pc[1:0]!=0. A redirect also overrides a
//     simultaneous stall.
//   - Stall (no redirect): pc_out, instr_pc, instr_valid, fetch_count and
//     state hold. The memory re-reads the same address, so the instruction
//     stays stable.
//   - Advance in RUN:
//     - If pc_out < PC_LIMIT (unsigned): instr_pc<=pc_out, instr_valid<=1,
//       pc_out<=pc_out+PC_STEP (mod 2^32 wrap, no error).
//     - If pc_out >= PC_LIMIT: instr_valid<=0, pc_out holds, state<=HALTED.
//   - HALTED: pc_out holds, instr_valid=0, stall ignored. Only a redirect
//     or reset leaves HALTED.
//   - fetch_count increments by 1 at every edge that sets instr_valid<=1.
//     It saturates at 16'hFFFF.
//   - All outputs are registered; no combinational input-to-output paths.
// TESTING
//   1 Reset release, no stall -> pc_out 0,4,8,... on consecutive edges.
//     instr_valid=1 from 1st edge with instr_pc 0,4,8,...
//   2 stall=1 for 3 cycles while pc_out=12 -> pc_out=12, instr_pc=8,
//     instr_valid=1 held. Resumes with instr_pc=12 one edge after release.
//   3 redirect=1, redirect_pc=4 while pc_out=16 -> next edge instr_valid=0,
//     pc_out=4. The following edge gives instr_pc=4, valid=1.
//   4 redirect and stall asserted together, target 8 -> redirect wins
//     (pc_out=8, one-cycle bubble). Redirect 0x0E -> pc_out=0x0C,
//     misalign_err=1 and stays 1.
//   5 Run from reset with no stalls -> after instr_pc=24 delivered,
//     state HALTED, instr_valid=0, fetch_count=7, pc_out=28.
//     Redirect to 0 from HALTED -> RUN resumes.
//   6 Assert rst asynchronously mid-stall with pc_out=20 -> outputs reset
//     immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and fetch-latency alignment for the instruction memory front end
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] PC_LIMIT = 32'd28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [15:0] fetch_count
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_nx;
    logic [31:0] pc_nx, ipc_nx;
    logic valid_nx, err_nx;
    logic [15:0] cnt_nx;

    // state register; the rest of the fetch registers share the same reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // next state and next register values: redirect > halted hold > stall > advance
    always_comb begin
        state_nx = state;
        pc_nx    = pc_out;
        ipc_nx   = instr_pc;
        valid_nx = instr_valid;
        err_nx   = misalign_err;
        cnt_nx   = fetch_count;
        if (redirect) begin
            pc_nx    = redirect_pc & ~32'h3;
            ipc_nx   = pc_out;
            valid_nx = 1'b0;
            state_nx = RUN;
            err_nx   = misalign_err | (|redirect_pc[1:0]);
        end else if (state == HALTED) begin
            valid_nx = 1'b0;
        end else if (!stall) begin
            ipc_nx = pc_out;
            if (pc_out < PC_LIMIT) begin
                valid_nx = 1'b1;
                pc_nx    = pc_out + PC_STEP;
                cnt_nx   = (&fetch_count) ? fetch_count : fetch_count + 16'd1;
            end else begin
                valid_nx = 1'b0;
                state_nx = HALTED;
            end
        end
    end

    // registered outputs so nothing reaches the ports combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out       <= RESET_PC;
            instr_pc     <= RESET_PC;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= 16'd0;
        end else begin
            pc_out       <= pc_nx;
            instr_pc     <= ipc_nx;
            instr_valid  <= valid_nx;
            halted       <= (state_nx == HALTED);
            misalign_err <= err_nx;
            fetch_count  <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed-vector bench for fetch_pc_unit
module tb_fetch_pc_unit;
    logic        clk, rst, stall, redirect;
    logic [31:0] redirect_pc, pc_out, instr_pc;
    logic        instr_valid, halted, misalign_err;
    logic [15:0] fetch_count;
    int errors = 0;
    int checks = 0;

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .pc_out(pc_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .halted(halted),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                              input logic v, input logic h, input logic e, input logic [15:0] c);
        check({tag, ".pc"}, pc_out, pc);
        check({tag, ".ipc"}, instr_pc, ipc);
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
        check({tag, ".err"}, {31'd0, misalign_err}, {31'd0, e});
        check({tag, ".cnt"}, {16'd0, fetch_count}, {16'd0, c});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        step;
        expect_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step;
            expect_all($sformatf("seq%0d", i), 4 * i, 4 * (i - 1), 1, 0, 0, 16'(i));
        end
        step;
        check("halt.pc", pc_out, 28);
        check("halt.valid", {31'd0, instr_valid}, 0);
        check("halt.halted", {31'd0, halted}, 1);
        check("halt.cnt", {16'd0, fetch_count}, 7);
        stall = 1'b1;
        step;
        expect_all("halt_stall", 28, instr_pc, 0, 1, 0, 7);
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'd0;
        step;
        expect_all("halt_redir", 0, 28, 0, 0, 0, 7);
        redirect = 1'b0;
        step;
        expect_all("resume", 4, 0, 1, 0, 0, 8);

        rst = 1'b1;
        step;
        expect_all("reset2", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step; step; step;
        expect_all("pre_stall", 12, 8, 1, 0, 0, 3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            expect_all($sformatf("stall%0d", i), 12, 8, 1, 0, 0, 3);
        end
        stall = 1'b0;
        step;
        expect_all("unstall", 16, 12, 1, 0, 0, 4);
        redirect = 1'b1; redirect_pc = 32'd4;
        step;
        expect_all("redir4", 4, 16, 0, 0, 0, 4);
        redirect = 1'b0;
        step;
        expect_all("after_redir4", 8, 4, 1, 0, 0, 5);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'd8;
        step;
        expect_all("redir_stall", 8, 8, 0, 0, 0, 5);
        redirect = 1'b0; stall = 1'b0;
        step;
        expect_all("after_rs", 12, 8, 1, 0, 0, 6);
        redirect = 1'b1; redirect_pc = 32'h0E;
        step;
        expect_all("misalign", 32'h0C, 12, 0, 0, 1, 6);
        redirect = 1'b0;
        step;
        expect_all("sticky1", 16, 32'h0C, 1, 0, 1, 7);
        step;
        expect_all("sticky2", 20, 16, 1, 0, 1, 8);
        stall = 1'b1;
        step;
        expect_all("stall20", 20, 16, 1, 0, 1, 8);
        #3;
        rst = 1'b1;
        #1;
        expect_all("async_rst", 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
